// File: rtl/midori64_round_key_seq_if.sv
// Key request / round-key stream bus of midori64_round_key_seq.
// master = key consumer side (drives start/key/ready), slave = the sequencer.
interface midori64_round_key_seq_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned BLK_W = 64;
  localparam int unsigned IDX_W = 4;

  logic             start;
  logic             decrypt;
  logic [KEY_W-1:0] master_key;
  logic             rk_ready;
  logic [BLK_W-1:0] wk;
  logic [BLK_W-1:0] rk;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, decrypt, master_key, rk_ready,
    input  wk, rk, rk_idx, rk_valid, busy, done
  );

  modport slave (
    input  start, decrypt, master_key, rk_ready,
    output wk, rk, rk_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/midori64_round_key_seq.sv
// Midori64 round-key sequencer: latches a 128-bit key and streams 15 round keys.
// Reverse (decryption) order is built only when MIDORI64_DECRYPT_EN is defined.
module midori64_round_key_seq (
  input logic                      clk,
  input logic                      rst,
  midori64_round_key_seq_if.slave  bus
);
  localparam int unsigned BLK_W  = 64;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned BETA_W = 16;
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(14);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t             state;
  logic [BLK_W-1:0]   k0_q;
  logic [BLK_W-1:0]   k1_q;
  logic [BLK_W-1:0]   wk_q;
  logic [BLK_W-1:0]   rk_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [IDX_W-1:0]   first_idx_c;
  logic [IDX_W-1:0]   next_idx_c;
  logic               last_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic [BLK_W-1:0]   rk_next_c;
  logic               accept_c;

  // Midori64 beta_i; MSB is the constant bit for cell 0 (most significant nibble).
  function automatic logic [BETA_W-1:0] beta(input logic [IDX_W-1:0] i);
    logic [BETA_W-1:0] b;
    case (i)
      4'd0:    b = 16'h15b3;
      4'd1:    b = 16'h78c0;
      4'd2:    b = 16'ha435;
      4'd3:    b = 16'h6213;
      4'd4:    b = 16'h104f;
      4'd5:    b = 16'hd170;
      4'd6:    b = 16'h0266;
      4'd7:    b = 16'h0bcc;
      4'd8:    b = 16'h9481;
      4'd9:    b = 16'h40b8;
      4'd10:   b = 16'h7197;
      4'd11:   b = 16'h228e;
      4'd12:   b = 16'h5130;
      4'd13:   b = 16'hf8ca;
      4'd14:   b = 16'hdf90;
      default: b = 16'h0000;
    endcase
    return b;
  endfunction

  // Constant bit j lands on the LSB of nibble j.
  function automatic logic [BLK_W-1:0] expand(input logic [BETA_W-1:0] b);
    logic [BLK_W-1:0] e;
    e = '0;
    for (int j = 0; j < 16; j++) begin
      e[4*j] = b[j];
    end
    return e;
  endfunction

`ifdef MIDORI64_DECRYPT_EN
  logic rev_q;

  assign first_idx_c = rev_q ? LAST_IDX : FIRST_IDX;
  assign next_idx_c  = rev_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
  assign last_c      = rev_q ? (idx_q == FIRST_IDX) : (idx_q == LAST_IDX);
`else
  logic unused_decrypt;

  assign unused_decrypt = bus.decrypt;
  assign first_idx_c    = FIRST_IDX;
  assign next_idx_c     = idx_q + IDX_W'(1);
  assign last_c         = (idx_q == LAST_IDX);
`endif

  // One shared ROM/expander: LOAD needs the first key, EMIT the next one.
  assign sel_idx_c = (state == LOAD) ? first_idx_c : next_idx_c;
  assign rk_next_c = (sel_idx_c[0] ? k1_q : k0_q) ^ expand(beta(sel_idx_c));
  assign accept_c  = valid_q & bus.rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k0_q    <= '0;
      k1_q    <= '0;
      wk_q    <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MIDORI64_DECRYPT_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            k0_q   <= bus.master_key[127:64];
            k1_q   <= bus.master_key[63:0];
            wk_q   <= bus.master_key[127:64] ^ bus.master_key[63:0];
            busy_q <= 1'b1;
`ifdef MIDORI64_DECRYPT_EN
            rev_q  <= bus.decrypt;
`endif
            state  <= LOAD;
          end
        end
        LOAD: begin
          idx_q   <= first_idx_c;
          rk_q    <= rk_next_c;
          valid_q <= 1'b1;
          state   <= EMIT;
        end
        EMIT: begin
          if (accept_c) begin
            if (last_c) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              idx_q <= next_idx_c;
              rk_q  <= rk_next_c;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wk       = wk_q;
  assign bus.rk       = rk_q;
  assign bus.rk_idx   = idx_q;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/midori64_round_key_seq.md
MIDORI64_ROUND_KEY_SEQ -- requirements
Module: midori64_round_key_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request to begin a key sequence; sampled only in IDLE.
REQ-004 SHALL have port decrypt  input  1  direction, sampled with start: 0 = forward round order, 1 = reverse round order.
REQ-005 SHALL have port master_key  input  128  key; K0 = [127:64], K1 = [63:0]; sampled with start.
REQ-006 SHALL have port rk_ready  input  1  consumer accepts the current round key.
REQ-007 SHALL have port wk  output  64  registered whitening key K0^K1, valid from the cycle after start until the next start.
REQ-008 SHALL have port rk  output  64  current round key.
REQ-009 SHALL have port rk_idx  output  4  round index of rk, 0..14.
REQ-010 SHALL have port rk_valid  output  1  rk/rk_idx valid.
REQ-011 SHALL have port busy  output  1  high in LOAD and EMIT.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last key is accepted.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> EMIT -> DONE -> IDLE.
REQ-014 IDLE: start=1 SHALL latch K0, K1, decrypt and wk, then go to LOAD; start=0 SHALL hold.
REQ-015 LOAD SHALL last exactly one cycle, set the index to 0 (forward) or 14 (reverse), then go to EMIT.
REQ-016 EMIT SHALL drive rk_valid=1 with rk = K(idx mod 2) XOR expand(beta_idx).
REQ-017 expand(beta_i) SHALL place bit j of the 16-bit Midori64 constant beta_i at bit 4*j of the 64-bit word, with all other bits 0.
REQ-018 beta_i SHALL be taken from a 15-entry constant ROM per the Midori64 specification.
REQ-019 Accept is rk_valid & rk_ready; on accept SHALL step idx by +1 (forward) or -1 (reverse).
REQ-020 While rk_valid=1 and rk_ready=0, rk and rk_idx SHALL hold stable.
REQ-021 Accepting idx 14 (forward) or idx 0 (reverse) SHALL go to DONE; the index SHALL NOT wrap.
REQ-022 First rk_valid SHALL occur 2 cycles after the start cycle.
REQ-023 With rk_ready tied high, keys SHALL be issued one per cycle, 15 consecutive cycles.
REQ-024 DONE SHALL pulse done=1 for one cycle with rk_valid=0, then return to IDLE.
REQ-025 start asserted outside IDLE, including in DONE, SHALL be ignored.
REQ-026 Master_key and decrypt changes after the start cycle SHALL NOT affect the running sequence.
REQ-027 rk SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE; wk, rk, rk_idx, K0/K1 registers = 0; rk_valid, busy, done = 0.
REQ-029 Reset mid-EMIT SHALL abort the sequence; done SHALL NOT pulse.
REQ-030 After rst deassertion the block SHALL accept start on the first clock edge.

Configuration
REQ-031 Macro MIDORI64_DECRYPT_EN SHALL control reverse-order support.
REQ-032 With MIDORI64_DECRYPT_EN defined, decrypt=1 SHALL select reverse order as specified above.
REQ-033 Without MIDORI64_DECRYPT_EN, the decrypt input SHALL be ignored and the sequence SHALL always be forward.
REQ-034 Without MIDORI64_DECRYPT_EN, the decrement logic SHALL be omitted; ports SHALL be unchanged.

Verification
REQ-035 Forward: master_key=128'h687ded3b3c85b3f35b1009863e2a8cbf, start, rk_ready=1 -> wk=64'h336de4bd02af3f4c; 15 keys idx 0..14, rk_i = K(i mod 2)^expand(beta_i); done 17 cycles after start.
REQ-036 Zero key: master_key=0, start -> wk=0, rk_i = expand(beta_i) exactly, idx 0..14.
REQ-037 Backpressure: same key, rk_ready low for 3 cycles at idx 5 -> rk/rk_idx stable at idx 5; no key skipped or duplicated; total cycles +3.
REQ-038 Reverse (MIDORI64_DECRYPT_EN): decrypt=1 -> idx 14..0, keys equal to the forward list reversed; done after idx 0.
REQ-039 Reset/abort: rst pulse at idx 7 -> all outputs 0 immediately, no done; new start yields a full 15-key sequence.
REQ-040 start pulses while busy and in DONE -> ignored; busy and sequence unaffected.
